// File: rtl/mtpsa_tuple_merge.sv
// Output-side tuple aligner: pairs one {digest, metadata} tuple with each outgoing packet.
// Build option: define MTPSA_TUPLE_STATS_EN to implement pkt_count, ovf_count and ovf_sticky.
module mtpsa_tuple_merge #(
    parameter int unsigned C_AXIS_DATA_WIDTH = 256,
    parameter int unsigned META_WIDTH        = 40,
    parameter int unsigned DIGEST_WIDTH      = 256,
    parameter int unsigned TUPLE_DEPTH       = 4,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]       s_axis_tkeep,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    input  logic                                 meta_valid,
    input  logic [META_WIDTH-1:0]                meta_data,
    input  logic                                 digest_valid,
    input  logic [DIGEST_WIDTH-1:0]              digest_data,
    output logic [C_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
    output logic [DIGEST_WIDTH+META_WIDTH-1:0]   m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 ovf_sticky,
    output logic [CNT_WIDTH-1:0]                 pkt_count,
    output logic [CNT_WIDTH-1:0]                 ovf_count
);

    localparam int unsigned TUSER_WIDTH = DIGEST_WIDTH + META_WIDTH;
    localparam int unsigned AW          = $clog2(TUPLE_DEPTH);
    localparam int unsigned OW          = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TUPLE_DEPTH-1:0][META_WIDTH-1:0]   meta_mem;
    logic [AW-1:0]                            meta_wr;
    logic [AW-1:0]                            meta_rd;
    logic [OW-1:0]                            meta_occ;
    logic                                     meta_full;
    logic                                     meta_empty;
    logic                                     meta_push;

    logic [TUPLE_DEPTH-1:0][DIGEST_WIDTH-1:0] digest_mem;
    logic [AW-1:0]                            digest_wr;
    logic [AW-1:0]                            digest_rd;
    logic [OW-1:0]                            digest_occ;
    logic                                     digest_full;
    logic                                     digest_empty;
    logic                                     digest_push;

    logic                                     avail;
    logic                                     pop;
    logic [TUSER_WIDTH-1:0]                   tuser_q;
    logic [TUSER_WIDTH-1:0]                   head_pair;

    // Packet payload passes straight through; only handshake and tuser are gated.
    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;

    assign meta_full    = (meta_occ == OW'(TUPLE_DEPTH));
    assign meta_empty   = (meta_occ == '0);
    assign digest_full  = (digest_occ == OW'(TUPLE_DEPTH));
    assign digest_empty = (digest_occ == '0);
    assign avail        = ~meta_empty & ~digest_empty;
    assign head_pair    = {digest_mem[digest_rd], meta_mem[meta_rd]};

    // A full FIFO still accepts a push in the cycle its head is popped.
    assign meta_push   = meta_valid   & (~meta_full   | pop);
    assign digest_push = digest_valid & (~digest_full | pop);

    // FSM state register
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pop && !s_axis_tlast) state_nxt = PKT;
            PKT:  if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_nxt = IDLE;
        endcase
    end

    // FSM outputs: first beat waits for a tuple pair and shows the FIFO heads directly
    always_comb begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tuser  = tuser_q;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                m_axis_tvalid = s_axis_tvalid & avail;
                s_axis_tready = m_axis_tready & avail;
                m_axis_tuser  = head_pair;
                pop           = s_axis_tvalid & m_axis_tready & avail;
            end
            PKT: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
            end
        endcase
    end

    // Tuple held for the remaining beats of the packet
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            tuser_q <= '0;
        end else if (pop) begin
            tuser_q <= head_pair;
        end
    end

    // Metadata FIFO
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            meta_mem <= '0;
            meta_wr  <= '0;
            meta_rd  <= '0;
            meta_occ <= '0;
        end else begin
            if (meta_push) begin
                meta_mem[meta_wr] <= meta_data;
                meta_wr           <= meta_wr + AW'(1);
            end
            if (pop) begin
                meta_rd <= meta_rd + AW'(1);
            end
            case ({meta_push, pop})
                2'b10:   meta_occ <= meta_occ + OW'(1);
                2'b01:   meta_occ <= meta_occ - OW'(1);
                default: meta_occ <= meta_occ;
            endcase
        end
    end

    // Digest FIFO
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            digest_mem <= '0;
            digest_wr  <= '0;
            digest_rd  <= '0;
            digest_occ <= '0;
        end else begin
            if (digest_push) begin
                digest_mem[digest_wr] <= digest_data;
                digest_wr             <= digest_wr + AW'(1);
            end
            if (pop) begin
                digest_rd <= digest_rd + AW'(1);
            end
            case ({digest_push, pop})
                2'b10:   digest_occ <= digest_occ + OW'(1);
                2'b01:   digest_occ <= digest_occ - OW'(1);
                default: digest_occ <= digest_occ;
            endcase
        end
    end

`ifdef MTPSA_TUPLE_STATS_EN
    localparam int unsigned CW1 = CNT_WIDTH + 1;

    logic                 meta_drop;
    logic                 digest_drop;
    logic [CNT_WIDTH-1:0] pkt_q;
    logic [CNT_WIDTH-1:0] ovf_q;
    logic                 sticky_q;
    logic [CW1-1:0]       ovf_sum;

    assign meta_drop   = meta_valid   & meta_full   & ~pop;
    assign digest_drop = digest_valid & digest_full & ~pop;
    // Extra carry bit catches wrap so a double drop near the top still saturates.
    assign ovf_sum     = {1'b0, ovf_q} + CW1'(meta_drop) + CW1'(digest_drop);

    // Saturating statistics and sticky overflow flag
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pkt_q    <= '0;
            ovf_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (pop && (pkt_q != '1)) begin
                pkt_q <= pkt_q + CNT_WIDTH'(1);
            end
            if (meta_drop || digest_drop) begin
                sticky_q <= 1'b1;
                ovf_q    <= ovf_sum[CNT_WIDTH] ? '1 : ovf_sum[CNT_WIDTH-1:0];
            end
        end
    end

    assign pkt_count  = pkt_q;
    assign ovf_count  = ovf_q;
    assign ovf_sticky = sticky_q;
`else
    assign pkt_count  = '0;
    assign ovf_count  = '0;
    assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mtpsa_tuple_merge.sv
// Directed bench for mtpsa_tuple_merge with a beat scoreboard; stats checks follow MTPSA_TUPLE_STATS_EN.
module tb_mtpsa_tuple_merge;

    localparam int unsigned DW = 256;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned MW = 40;
    localparam int unsigned GW = 256;
    localparam int unsigned UW = GW + MW;
    localparam int unsigned CW = 32;

`ifdef MTPSA_TUPLE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    logic          axis_aclk;
    logic          axis_resetn;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          meta_valid;
    logic [MW-1:0] meta_data;
    logic          digest_valid;
    logic [GW-1:0] digest_data;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          ovf_sticky;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] ovf_count;

    beat_t src_q[$];
    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    quiet   = 1'b0;

    mtpsa_tuple_merge dut (
        .axis_aclk     (axis_aclk),
        .axis_resetn   (axis_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .meta_valid    (meta_valid),
        .meta_data     (meta_data),
        .digest_valid  (digest_valid),
        .digest_data   (digest_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .ovf_sticky    (ovf_sticky),
        .pkt_count     (pkt_count),
        .ovf_count     (ovf_count)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    task automatic chk(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [UW-1:0] pair(input logic [7:0] d, input logic [7:0] m);
        return {GW'(d), MW'(m)};
    endfunction

    task automatic push_tuple(input logic [7:0] m, input logic [7:0] d);
        meta_valid   = 1'b1;
        meta_data    = MW'(m);
        digest_valid = 1'b1;
        digest_data  = GW'(d);
    endtask

    task automatic send_pkt(input int nbeats, input logic [UW-1:0] user, input int tag);
        beat_t       b;
        logic [31:0] w;
        for (int i = 0; i < nbeats; i++) begin
            w      = (32'(tag) << 8) | 32'(i);
            b.data = {8{w}};
            b.keep = (i == nbeats - 1) ? KW'(32'h0000_ffff) : '1;
            b.last = (i == nbeats - 1);
            b.user = user;
            src_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    // One clock: present the source head, check outputs at negedge, advance after the edge.
    task automatic tick();
        bit hs;
        if (src_q.size() != 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src_q[0].data;
            s_axis_tkeep  = src_q[0].keep;
            s_axis_tlast  = src_q[0].last;
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
        @(negedge axis_aclk);
        if (quiet) chk("stall_no_tvalid", m_axis_tvalid, 0);
        if (m_axis_tvalid === 1'b1) begin
            chk("tready_follow", s_axis_tready, m_axis_tready);
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", m_axis_tvalid, 0);
            end else begin
                chk("tdata", m_axis_tdata, exp_q[0].data);
                chk("tkeep", m_axis_tkeep, exp_q[0].keep);
                chk("tlast", m_axis_tlast, exp_q[0].last);
                chk("tuser", m_axis_tuser, exp_q[0].user);
                if (m_axis_tready) void'(exp_q.pop_front());
            end
        end
        hs = s_axis_tvalid && s_axis_tready;
        @(posedge axis_aclk);
        #1;
        if (hs && src_q.size() != 0) void'(src_q.pop_front());
        meta_valid   = 1'b0;
        digest_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", UW'(exp_q.size()), 0);
    endtask

    initial begin
        axis_resetn   = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        meta_valid    = 1'b0;
        meta_data     = '0;
        digest_valid  = 1'b0;
        digest_data   = '0;
        m_axis_tready = 1'b1;

        // Reset state
        #3;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_ovf_count", ovf_count, 0);
        chk("rst_sticky", ovf_sticky, 0);
        repeat (3) @(posedge axis_aclk);
        #1;
        axis_resetn = 1'b1;

        // Packet waits until both tuples exist
        quiet = 1'b1;
        tick(); tick();
        send_pkt(3, pair(8'hAA, 8'h11), 1);
        tick(); tick(); tick();
        meta_valid = 1'b1; meta_data = MW'(8'h11);
        tick();
        tick(); tick(); tick();
        digest_valid = 1'b1; digest_data = GW'(8'hAA);
        tick();
        quiet = 1'b0;
        drain(20);
        chk("t1_pkt_count", pkt_count, STATS ? 32'd1 : 32'd0);

        // Single-beat packet, FSM stays IDLE and FIFOs end empty
        push_tuple(8'h22, 8'hBB);
        tick();
        send_pkt(1, pair(8'hBB, 8'h22), 2);
        drain(10);
        send_pkt(1, pair(8'hBC, 8'h23), 3);
        quiet = 1'b1;
        tick(); tick(); tick();
        push_tuple(8'h23, 8'hBC);
        tick();
        quiet = 1'b0;
        drain(10);

        // Overflow: fifth push of each tuple dropped
        for (int i = 0; i < 5; i++) begin
            push_tuple(8'(8'h31 + i), 8'(8'hC1 + i));
            tick();
        end
        chk("t3_ovf_count", ovf_count, STATS ? 32'd2 : 32'd0);
        chk("t3_sticky", ovf_sticky, STATS ? 1'b1 : 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_pkt(2, pair(8'(8'hC1 + i), 8'(8'h31 + i)), 10 + i);
        end
        drain(40);
        chk("t3_pkt_count", pkt_count, STATS ? 32'd7 : 32'd0);

        // Downstream backpressure mid-packet
        push_tuple(8'h44, 8'hD4);
        tick();
        send_pkt(4, pair(8'hD4, 8'h44), 20);
        m_axis_tready = 1'b1; tick();
        m_axis_tready = 1'b0; tick();
        m_axis_tready = 1'b0; tick();
        m_axis_tready = 1'b1; tick();
        drain(20);
        chk("t4_pkt_count", pkt_count, STATS ? 32'd8 : 32'd0);

        // Push into full FIFOs coincident with the first-beat pop
        for (int i = 0; i < 4; i++) begin
            push_tuple(8'(8'h51 + i), 8'(8'hE1 + i));
            tick();
        end
        send_pkt(2, pair(8'hE1, 8'h51), 30);
        push_tuple(8'h55, 8'hE5);
        tick();
        for (int i = 1; i < 5; i++) begin
            send_pkt(1, pair(8'(8'hE1 + i), 8'(8'h51 + i)), 30 + i);
        end
        drain(40);
        chk("t5_ovf_count", ovf_count, STATS ? 32'd2 : 32'd0);
        chk("t5_pkt_count", pkt_count, STATS ? 32'd13 : 32'd0);

        // Asynchronous reset mid-packet
        push_tuple(8'h66, 8'hF6);
        tick();
        send_pkt(4, pair(8'hF6, 8'h66), 40);
        tick(); tick();
        #2;
        axis_resetn = 1'b0;
        #1;
        chk("t6_tvalid", m_axis_tvalid, 0);
        chk("t6_tready", s_axis_tready, 0);
        chk("t6_tuser", m_axis_tuser, 0);
        chk("t6_pkt_count", pkt_count, 0);
        chk("t6_ovf_count", ovf_count, 0);
        chk("t6_sticky", ovf_sticky, 0);
        src_q.delete();
        exp_q.delete();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(posedge axis_aclk);
        #1;
        axis_resetn = 1'b1;
        send_pkt(1, pair(8'h07, 8'h77), 50);
        quiet = 1'b1;
        tick(); tick(); tick();
        push_tuple(8'h77, 8'h07);
        tick();
        quiet = 1'b0;
        drain(10);
        chk("t6_post_pkt_count", pkt_count, STATS ? 32'd1 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
